// File: rtl/flipflop_regfile_pkg.sv
// Shared definitions for the flip-flop register file: error codes and the op request bundle.
// Optional write-protect support is enabled with the FFRF_LOCK_EN macro.
package flipflop_regfile_pkg;
    localparam int ERR_W = 3;

    localparam logic [ERR_W-1:0] ERR_NONE       = 3'd0;
    localparam logic [ERR_W-1:0] ERR_CONFLICT   = 3'd1;
    localparam logic [ERR_W-1:0] ERR_RANGE      = 3'd2;
    localparam logic [ERR_W-1:0] ERR_RD_INVALID = 3'd3;
    localparam logic [ERR_W-1:0] ERR_LOCKED     = 3'd4;

    typedef struct packed {
        logic wr;
        logic rd;
        logic clr;
        logic lock;
    } op_t;
endpackage

// File: rtl/flipflop_regfile_entry.sv
// One register-file entry: data register, valid bit and (with FFRF_LOCK_EN) a sticky lock bit.
// The top guarantees at most one enable is high and that locked entries never see we/clr.
module flipflop_regfile_entry #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             we,
    input  logic             clr,
`ifdef FFRF_LOCK_EN
    input  logic             lock_set,
    output logic             locked,
`endif
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             valid
);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (we) begin
            q     <= din;
            valid <= 1'b1;
        end else if (clr) begin
            // data is intentionally retained; only the entry is marked empty
            valid <= 1'b0;
        end
    end

`ifdef FFRF_LOCK_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)       locked <= 1'b0;
        else if (lock_set) locked <= 1'b1;
    end
`endif
endmodule

// File: rtl/flipflop_regfile.sv
// WIDTH x DEPTH flop register file with valid tracking, occupancy, registered read and coded errors.
// Define FFRF_LOCK_EN to add the lock port and per-entry write protection.
module flipflop_regfile
    import flipflop_regfile_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] din,
    input  logic [AW-1:0]    addr,
    input  logic             wr,
    input  logic             rd,
    input  logic             clr,
`ifdef FFRF_LOCK_EN
    input  logic             lock,
`endif
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             error,
    output logic [ERR_W-1:0] err_code,
    output logic [DEPTH-1:0] ff_status_bar,
    output logic [AW:0]      occupancy,
    output logic             full,
    output logic             empty
);
    op_t                          op;
    logic [DEPTH-1:0]             valid_vec;
    logic [DEPTH-1:0]             lock_vec;
    logic [DEPTH-1:0][WIDTH-1:0]  q_vec;
    logic                         sel_valid, sel_lock, in_range, op_ok;
    logic [WIDTH-1:0]             sel_data;
    logic [ERR_W-1:0]             err_nxt;

    assign op.wr  = wr;
    assign op.rd  = rd;
    assign op.clr = clr;
`ifdef FFRF_LOCK_EN
    assign op.lock = lock;
`else
    assign op.lock = 1'b0;
    assign lock_vec = '0;
`endif

    // DEPTH need not be a power of two, so addresses past the last entry must be caught
    assign in_range = (int'(addr) < DEPTH);

    always_comb begin
        sel_valid = 1'b0;
        sel_lock  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == AW'(i)) begin
                sel_valid = valid_vec[i];
                sel_lock  = lock_vec[i];
                sel_data  = q_vec[i];
            end
        end
    end

    always_comb begin
        err_nxt = ERR_NONE;
        if ($countones(op) > 1)                  err_nxt = ERR_CONFLICT;
        else if (op != '0 && !in_range)          err_nxt = ERR_RANGE;
        else if ((op.wr || op.clr) && sel_lock)  err_nxt = ERR_LOCKED;
        else if (op.rd && !sel_valid)            err_nxt = ERR_RD_INVALID;
    end

    assign op_ok = (op != '0) && (err_nxt == ERR_NONE);

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic hit;
        assign hit = op_ok && (addr == AW'(i));

        flipflop_regfile_entry #(.WIDTH(WIDTH)) u_entry (
            .clk      (clk),
            .resetn   (resetn),
            .we       (hit && op.wr),
            .clr      (hit && op.clr),
`ifdef FFRF_LOCK_EN
            .lock_set (hit && op.lock),
            .locked   (lock_vec[i]),
`endif
            .din      (din),
            .q        (q_vec[i]),
            .valid    (valid_vec[i])
        );
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
            occupancy  <= '0;
        end else begin
            dout_valid <= op_ok && op.rd;
            if (op_ok && op.rd) dout <= sel_data;
            error    <= (err_nxt != ERR_NONE);
            err_code <= err_nxt;
            // count only valid-state transitions, so it stays within 0..DEPTH
            if (op_ok && op.wr && !sel_valid)
                occupancy <= occupancy + (AW+1)'(1);
            else if (op_ok && op.clr && sel_valid)
                occupancy <= occupancy - (AW+1)'(1);
        end
    end

    assign ff_status_bar = ~valid_vec;
    assign full          = (occupancy == (AW+1)'(DEPTH));
    assign empty         = (occupancy == '0);
endmodule

// File: tb/tb_flipflop_regfile.sv
// Self-checking bench: directed scenarios plus random ops against an array-based reference model.
// Honours FFRF_LOCK_EN for the lock port and lock scenarios.
module tb_flipflop_regfile;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] din = '0;
    logic [2:0] addr = '0;
    logic       wr = 0, rd = 0, clr = 0, lock = 0;
    logic [7:0] dout;
    logic       dout_valid, error, full, empty;
    logic [2:0] err_code;
    logic [7:0] ff_status_bar;
    logic [3:0] occupancy;

    logic [7:0] din5 = '0;
    logic [2:0] addr5 = '0;
    logic       wr5 = 0, rd5 = 0, clr5 = 0, lock5 = 0;
    logic [7:0] dout5;
    logic       dout_valid5, error5, full5, empty5;
    logic [2:0] err_code5;
    logic [4:0] ff_status_bar5;
    logic [3:0] occupancy5;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    flipflop_regfile #(.WIDTH(8), .DEPTH(8)) dut (
        .clk(clk), .resetn(resetn), .din(din), .addr(addr), .wr(wr), .rd(rd), .clr(clr),
`ifdef FFRF_LOCK_EN
        .lock(lock),
`endif
        .dout(dout), .dout_valid(dout_valid), .error(error), .err_code(err_code),
        .ff_status_bar(ff_status_bar), .occupancy(occupancy), .full(full), .empty(empty)
    );

    flipflop_regfile #(.WIDTH(8), .DEPTH(5)) dut5 (
        .clk(clk), .resetn(resetn), .din(din5), .addr(addr5), .wr(wr5), .rd(rd5), .clr(clr5),
`ifdef FFRF_LOCK_EN
        .lock(lock5),
`endif
        .dout(dout5), .dout_valid(dout_valid5), .error(error5), .err_code(err_code5),
        .ff_status_bar(ff_status_bar5), .occupancy(occupancy5), .full(full5), .empty(empty5)
    );

    // reference model: plain arrays updated by the op rules
    logic [7:0] m_mem [8];
    bit         m_val [8];
    bit         m_lck [8];
    logic [7:0] m_dout;
    bit         m_dv, m_err;
    int         m_code;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_mem[i] = '0; m_val[i] = 0; m_lck[i] = 0;
        end
        m_dout = '0; m_dv = 0; m_err = 0; m_code = 0;
    endfunction

    function automatic void model_op(bit w, bit r, bit c, bit lk, int a, logic [7:0] d);
        int n = int'(w) + int'(r) + int'(c) + int'(lk);
        m_dv = 0; m_code = 0;
        if (n > 1)                          m_code = 1;
        else if (n == 1 && a >= 8)          m_code = 2;
        else if (n == 1 && (w || c) && m_lck[a]) m_code = 4;
        else if (n == 1 && r && !m_val[a])  m_code = 3;
        else if (n == 1) begin
            if (w)  begin m_mem[a] = d; m_val[a] = 1; end
            if (r)  begin m_dout = m_mem[a]; m_dv = 1; end
            if (c)  m_val[a] = 0;
            if (lk) m_lck[a] = 1;
        end
        m_err = (m_code != 0);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        int   occ = 0;
        logic [7:0] bar = '1;
        for (int i = 0; i < 8; i++) if (m_val[i]) begin occ++; bar[i] = 1'b0; end
        chk({tag, ".dout"},  dout, m_dout);
        chk({tag, ".dv"},    dout_valid, m_dv);
        chk({tag, ".err"},   error, m_err);
        chk({tag, ".code"},  err_code, m_code);
        chk({tag, ".bar"},   ff_status_bar, bar);
        chk({tag, ".occ"},   occupancy, occ);
        chk({tag, ".full"},  full, occ == 8);
        chk({tag, ".empty"}, empty, occ == 0);
    endtask

    // drive one op at the falling edge, let it clock in, then compare against the model
    task automatic step(string tag, bit w, bit r, bit c, bit lk, int a, logic [7:0] d);
        wr = w; rd = r; clr = c; lock = lk; addr = a[2:0]; din = d;
        @(posedge clk); #1;
        model_op(w, r, c, lk, a, d);
        check_all(tag);
        @(negedge clk);
        wr = 0; rd = 0; clr = 0; lock = 0;
    endtask

    task automatic step5(string tag, bit w, bit r, bit c, int a, logic [7:0] d,
                         bit e_err, int e_code, bit e_dv, logic [7:0] e_dout, int e_occ);
        wr5 = w; rd5 = r; clr5 = c; addr5 = a[2:0]; din5 = d;
        @(posedge clk); #1;
        chk({tag, ".err"},  error5, e_err);
        chk({tag, ".code"}, err_code5, e_code);
        chk({tag, ".dv"},   dout_valid5, e_dv);
        chk({tag, ".dout"}, dout5, e_dout);
        chk({tag, ".occ"},  occupancy5, e_occ);
        @(negedge clk);
        wr5 = 0; rd5 = 0; clr5 = 0;
    endtask

    initial begin
        model_reset();
        #1;
        check_all("reset");
        chk("reset.bar5", ff_status_bar5, 5'h1F);
        chk("reset.empty5", empty5, 1);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        step("wr0", 1, 0, 0, 0, 0, 8'hF0);
        step("wr1", 1, 0, 0, 0, 1, 8'hAA);
        step("wr2", 1, 0, 0, 0, 2, 8'h0F);
        chk("bar_after3", ff_status_bar, 8'hF8);
        chk("occ_after3", occupancy, 3);
        step("rd2", 0, 1, 0, 0, 2, 8'h00);
        chk("rd2_data", dout, 8'h0F);
        chk("rd2_dv", dout_valid, 1);
        step("idle", 0, 0, 0, 0, 0, 8'h00);
        chk("idle_hold", dout, 8'h0F);
        chk("idle_dv", dout_valid, 0);
        step("conflict", 1, 1, 0, 0, 1, 8'h33);
        chk("conflict_code", err_code, 1);
        step("rd1", 0, 1, 0, 0, 1, 8'h00);
        chk("rd1_kept", dout, 8'hAA);
        step("rd5_inv", 0, 1, 0, 0, 5, 8'h00);
        chk("rd5_code", err_code, 3);
        chk("rd5_hold", dout, 8'hAA);
        step("clr0", 0, 0, 1, 0, 0, 8'h00);
        chk("clr0_occ", occupancy, 2);
        chk("clr0_bar0", ff_status_bar[0], 1);
        step("clr0_again", 0, 0, 1, 0, 0, 8'h00);
        step("ovw1", 1, 0, 0, 0, 1, 8'h55);
        chk("ovw1_occ", occupancy, 2);
        step("idle_err_drop", 0, 0, 0, 0, 0, 8'h00);

`ifdef FFRF_LOCK_EN
        step("lock1", 0, 0, 0, 1, 1, 8'h00);
        step("wr_locked", 1, 0, 0, 0, 1, 8'h11);
        chk("wr_locked_code", err_code, 4);
        step("clr_locked", 0, 0, 1, 0, 1, 8'h00);
        step("rd_locked", 0, 1, 0, 0, 1, 8'h00);
        chk("rd_locked_data", dout, 8'h55);
        step("lock_conflict", 1, 0, 0, 1, 3, 8'h22);
`endif

        step5("d5_wr4",  1, 0, 0, 4, 8'h3C, 0, 0, 0, 8'h00, 1);
        step5("d5_rd6",  0, 1, 0, 6, 8'h00, 1, 2, 0, 8'h00, 1);
        step5("d5_rd4",  0, 1, 0, 4, 8'h00, 0, 0, 1, 8'h3C, 1);
        step5("d5_clr5", 0, 0, 1, 5, 8'h00, 1, 2, 0, 8'h3C, 1);
        step5("d5_wr7",  1, 0, 0, 7, 8'h99, 1, 2, 0, 8'h3C, 1);
        step5("d5_conf", 1, 0, 1, 6, 8'h99, 1, 1, 0, 8'h3C, 1);

        for (int n = 0; n < 300; n++) begin
            int  kind = $urandom_range(0, 9);
            int  a = $urandom_range(0, 7);
            logic [7:0] d = 8'($urandom);
            case (kind)
                0, 1, 2, 3: step("rnd_wr",  1, 0, 0, 0, a, d);
                4, 5, 6:    step("rnd_rd",  0, 1, 0, 0, a, d);
                7:          step("rnd_clr", 0, 0, 1, 0, a, d);
                8:          step("rnd_idle", 0, 0, 0, 0, a, d);
                default: begin
                    int p = $urandom_range(0, 2);
                    step("rnd_conf", p != 2, p != 1, p != 0, 0, a, d);
                end
            endcase
        end

        for (int a = 0; a < 8; a++) step("fill", 1, 0, 0, 0, a, 8'(8'hC0 + a));
        chk("fill_full", full, 1);
        chk("fill_bar", ff_status_bar, 8'h00);
        step("rd_full7", 0, 1, 0, 0, 7, 8'h00);
        chk("rd_full7_data", dout, 8'hC7);

        // reset asserted while a write is pending: it must never land
        wr = 1; addr = 3'd3; din = 8'h77;
        #2 resetn = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        chk("midrst_full", full, 0);
        chk("midrst_empty5", empty5, 1);
        @(negedge clk);
        wr = 0;
        resetn = 1'b1;
        @(negedge clk);
        step("post_rst_rd3", 0, 1, 0, 0, 3, 8'h00);
        chk("post_rst_code", err_code, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
